multi_cycle_controller: RTL and testbench

//  Main control FSM of the multi-cycle MIPS core. Sequences the Instruction_Register (IRwrite), PC, memory, register file and ALU.

---
 rtl/multi_cycle_controller_pkg.sv | 73 +++++++
 rtl/multi_cycle_controller_if.sv | 22 ++
 rtl/multi_cycle_controller_mem_wait_timer.sv | 23 ++
 rtl/multi_cycle_controller.sv | 109 ++++++++++
 tb/tb_multi_cycle_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// mux select codes, fault codes, and the per-state Moore control word.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // IRwrite is absent: it only ever depends on mem_ready in FETCH.
    typedef struct packed {
        logic       PCWrite;
        logic       Branch;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSrc;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.MemRead = 1'b1; c.ALUSrcB = SRCB_4;
                            c.ALUOp = ALUOP_ADD; c.PCSrc = PCSRC_ALU; end
            S_DECODE: c.ALUSrcB = SRCB_IMM_SH2;
            S_MEMADR,
            S_ADDIEX: begin c.ALUSrcA = 1'b1; c.ALUSrcB = SRCB_IMM; end
            S_MEMRD:  begin c.MemRead = 1'b1; c.IorD = 1'b1; end
            S_MEMWB:  begin c.RegWrite = 1'b1; c.MemtoReg = 1'b1; end
            S_MEMWR:  begin c.MemWrite = 1'b1; c.IorD = 1'b1; end
            S_EXEC:   begin c.ALUSrcA = 1'b1; c.ALUSrcB = SRCB_B; c.ALUOp = ALUOP_FUNCT; end
            S_ALUWB:  begin c.RegWrite = 1'b1; c.RegDst = 1'b1; end
            S_ADDIWB: c.RegWrite = 1'b1;
            S_BRANCH: begin c.ALUSrcA = 1'b1; c.ALUOp = ALUOP_SUB; c.Branch = 1'b1;
                            c.PCSrc = PCSRC_ALUOUT; end
            S_JUMP:   begin c.PCWrite = 1'b1; c.PCSrc = PCSRC_JUMP; end
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Opcode/memory handshake in, control word and status out, for the multi-cycle controller.
interface multi_cycle_controller_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             IRwrite, PCWrite, Branch, IorD, MemRead, MemWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSrc;
    logic             halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    modport master (
        output opcode, mem_ready,
        input  IRwrite, PCWrite, Branch, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, halted, fault, cycle_cnt, instr_cnt
    );
    modport slave (
        input  opcode, mem_ready,
        output IRwrite, PCWrite, Branch, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, halted, fault, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multi_cycle_controller_mem_wait_timer.sv
// Counts cycles spent in a memory wait state; o_expired marks the last permitted cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // r_cnt == completed wait cycles, so MEM_TIMEOUT-1 means this is cycle MEM_TIMEOUT.
    assign o_expired = (r_cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      r_cnt <= '0;
        else if (i_clear)                r_cnt <= '0;
        else if (i_enable && !o_expired) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS core. Optional performance counters
// are built only when MULTI_CYCLE_PERF_EN is defined.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic reset,
    multi_cycle_controller_if.slave mc
);
    state_e     r_state, w_next;
    ctrl_t      r_ctrl;
    logic [1:0] r_fault;
    logic       w_wait_st, w_expired, w_fetch_ack;

    assign w_wait_st   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_fetch_ack = (r_state == S_FETCH) && mc.mem_ready;

    // Any state change restarts the wait count, including MEMWR -> FETCH.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_next != r_state),
        .i_enable  (w_wait_st),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mc.mem_ready) w_next = S_DECODE; else if (w_expired) w_next = S_HALT;
            S_DECODE: begin
                case (mc.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: w_next = (mc.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mc.mem_ready) w_next = S_MEMWB; else if (w_expired) w_next = S_HALT;
            S_MEMWR:  if (mc.mem_ready) w_next = S_FETCH; else if (w_expired) w_next = S_HALT;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_fault <= FAULT_NONE;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
            if (w_next == S_HALT && r_state != S_HALT)
                r_fault <= (r_state == S_DECODE) ? FAULT_ILLEGAL : FAULT_TIMEOUT;
        end
    end

    assign mc.IRwrite  = w_fetch_ack;
    assign mc.PCWrite  = r_ctrl.PCWrite | w_fetch_ack;
    assign mc.Branch   = r_ctrl.Branch;
    assign mc.IorD     = r_ctrl.IorD;
    assign mc.MemRead  = r_ctrl.MemRead;
    assign mc.MemWrite = r_ctrl.MemWrite;
    assign mc.MemtoReg = r_ctrl.MemtoReg;
    assign mc.RegDst   = r_ctrl.RegDst;
    assign mc.RegWrite = r_ctrl.RegWrite;
    assign mc.ALUSrcA  = r_ctrl.ALUSrcA;
    assign mc.ALUSrcB  = r_ctrl.ALUSrcB;
    assign mc.ALUOp    = r_ctrl.ALUOp;
    assign mc.PCSrc    = r_ctrl.PCSrc;
    assign mc.halted   = r_ctrl.halted;
    assign mc.fault    = r_fault;

`ifdef MULTI_CYCLE_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
    logic             w_retire;

    // Only terminal states (never IDLE, never a FETCH wait) move into FETCH.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_retire)                               r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign mc.cycle_cnt = r_cycle_cnt;
    assign mc.instr_cnt = r_instr_cnt;
`else
    assign mc.cycle_cnt = {CNT_W{1'b0}};
    assign mc.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Instruction-level scoreboard for multi_cycle_controller: each instruction is
// expanded into its expected per-cycle control words and compared cycle by cycle.
module tb_multi_cycle_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
`ifdef MULTI_CYCLE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4;
    localparam int P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_ADDIEX = 9;
    localparam int P_ADDIWB = 10, P_BRANCH = 11, P_JUMP = 12, P_HALT = 13;

    string pname [0:13] = '{"idle", "fetch", "decode", "memadr", "memrd", "memwb", "memwr",
                            "exec", "aluwb", "addiex", "addiwb", "branch", "jump", "halt"};

    typedef struct {
        int         ph;
        logic       rdy;
        logic [5:0] op;
        logic [1:0] flt;
        bit         ret;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_cycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mc    (bus)
    );

    logic [18:0] obs;
    assign obs = {bus.IRwrite, bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSrc, bus.halted, bus.fault};

    int    n_tests = 0, n_fail = 0;
    int    m_cyc = 0, m_ins = 0;
    step_t q [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word per phase, bit layout matches obs.
    function automatic logic [18:0] exp_word(int ph, logic rdy, logic [1:0] flt);
        logic [18:0] w = '0;
        case (ph)
            P_FETCH:  begin w[18] = rdy; w[17] = rdy; w[14] = 1'b1; w[8:7] = 2'b01; end
            P_DECODE: w[8:7] = 2'b11;
            P_MEMADR, P_ADDIEX: begin w[9] = 1'b1; w[8:7] = 2'b10; end
            P_MEMRD:  begin w[15] = 1'b1; w[14] = 1'b1; end
            P_MEMWB:  begin w[12] = 1'b1; w[10] = 1'b1; end
            P_MEMWR:  begin w[15] = 1'b1; w[13] = 1'b1; end
            P_EXEC:   begin w[9] = 1'b1; w[6:5] = 2'b10; end
            P_ALUWB:  begin w[11] = 1'b1; w[10] = 1'b1; end
            P_ADDIWB: w[10] = 1'b1;
            P_BRANCH: begin w[16] = 1'b1; w[9] = 1'b1; w[6:5] = 2'b01; w[4:3] = 2'b01; end
            P_JUMP:   begin w[17] = 1'b1; w[4:3] = 2'b10; end
            P_HALT:   begin w[2] = 1'b1; w[1:0] = flt; end
            default:  w = '0;
        endcase
        return w;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pickw();
        if ($urandom_range(0, 7) == 0) return MEM_TIMEOUT - 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic push(int ph, logic rdy, logic [5:0] op, logic [1:0] flt, bit ret);
        step_t s;
        s.ph = ph; s.rdy = rdy; s.op = op; s.flt = flt; s.ret = ret;
        q.push_back(s);
    endtask

    // fw/mw: cycles mem_ready stays low before the fetch / data access completes.
    task automatic add_instr(logic [5:0] op, int fw, int mw);
        for (int i = 0; i < fw; i++) push(P_FETCH, 1'b0, op, 2'b00, 1'b0);
        push(P_FETCH, 1'b1, op, 2'b00, 1'b0);
        push(P_DECODE, rnd1(), op, 2'b00, 1'b0);
        case (op)
            OP_LW: begin
                push(P_MEMADR, rnd1(), op, 2'b00, 1'b0);
                for (int i = 0; i < mw; i++) push(P_MEMRD, 1'b0, op, 2'b00, 1'b0);
                push(P_MEMRD, 1'b1, op, 2'b00, 1'b0);
                push(P_MEMWB, rnd1(), op, 2'b00, 1'b1);
            end
            OP_SW: begin
                push(P_MEMADR, rnd1(), op, 2'b00, 1'b0);
                for (int i = 0; i < mw; i++) push(P_MEMWR, 1'b0, op, 2'b00, 1'b0);
                push(P_MEMWR, 1'b1, op, 2'b00, 1'b1);
            end
            OP_R:    begin push(P_EXEC, rnd1(), op, 2'b00, 1'b0); push(P_ALUWB, rnd1(), op, 2'b00, 1'b1); end
            OP_ADDI: begin push(P_ADDIEX, rnd1(), op, 2'b00, 1'b0); push(P_ADDIWB, rnd1(), op, 2'b00, 1'b1); end
            OP_BEQ:  push(P_BRANCH, rnd1(), op, 2'b00, 1'b1);
            OP_J:    push(P_JUMP, rnd1(), op, 2'b00, 1'b1);
            default: for (int i = 0; i < 5; i++) push(P_HALT, rnd1(), op, 2'b01, 1'b0);
        endcase
    endtask

    task automatic run();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset = 1'b1;
            bus.opcode = s.op;
            bus.mem_ready = s.rdy;
            #1;
            chk({"ctl_", pname[s.ph]}, 32'(obs), 32'(exp_word(s.ph, s.rdy, s.flt)));
            chk("cycle_cnt", bus.cycle_cnt, PERF ? 32'(m_cyc) : 32'd0);
            chk("instr_cnt", bus.instr_cnt, PERF ? 32'(m_ins) : 32'd0);
            if (s.ph != P_IDLE && s.ph != P_HALT) m_cyc++;
            if (s.ret) m_ins++;
        end
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock.
    task automatic start();
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.mem_ready = rnd1();
        #1;
        chk("rst_ctl", 32'(obs), 32'd0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
        chk("rst_instr_cnt", bus.instr_cnt, 32'd0);
        m_cyc = 0;
        m_ins = 0;
        push(P_IDLE, rnd1(), 6'd0, 2'b00, 1'b0);
    endtask

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        reset = 1'b0;
        bus.opcode = '0;
        bus.mem_ready = 1'b0;

        // Directed opening: R, lw with 3 memory waits, beq, j, then sw/addi mix.
        start();
        add_instr(OP_R, 0, 0);
        add_instr(OP_LW, 0, 3);
        add_instr(OP_BEQ, 0, 0);
        add_instr(OP_J, 0, 0);
        add_instr(OP_SW, 0, 0);
        add_instr(OP_ADDI, 1, 0);
        add_instr(OP_R, 0, 0);
        add_instr(OP_SW, 0, 0);
        add_instr(OP_BEQ, 0, 0);
        run();

        for (int i = 0; i < 60; i++)
            add_instr(legal[$urandom_range(0, 5)], pickw(), pickw());
        add_instr(OP_LW, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1);
        add_instr(OP_SW, 0, MEM_TIMEOUT - 1);
        run();

        // Illegal opcodes: sticky HALT with fault 01, cleared by reset.
        add_instr(6'b111111, 0, 0);
        run();
        start();
        do op = 6'($urandom_range(0, 63)); while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        add_instr(OP_R, 0, 0);
        add_instr(op, 2, 0);
        run();

        // Fetch timeout.
        start();
        add_instr(OP_ADDI, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT; i++) push(P_FETCH, 1'b0, OP_R, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) push(P_HALT, rnd1(), OP_R, 2'b10, 1'b0);
        run();

        // Load data timeout.
        start();
        push(P_FETCH, 1'b1, OP_LW, 2'b00, 1'b0);
        push(P_DECODE, 1'b1, OP_LW, 2'b00, 1'b0);
        push(P_MEMADR, 1'b0, OP_LW, 2'b00, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) push(P_MEMRD, 1'b0, OP_LW, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) push(P_HALT, rnd1(), OP_LW, 2'b10, 1'b0);
        run();

        // Reset lands in the middle of a store wait, then normal operation resumes.
        start();
        add_instr(OP_R, 0, 0);
        push(P_FETCH, 1'b1, OP_SW, 2'b00, 1'b0);
        push(P_DECODE, 1'b0, OP_SW, 2'b00, 1'b0);
        push(P_MEMADR, 1'b1, OP_SW, 2'b00, 1'b0);
        push(P_MEMWR, 1'b0, OP_SW, 2'b00, 1'b0);
        push(P_MEMWR, 1'b0, OP_SW, 2'b00, 1'b0);
        run();
        start();
        add_instr(OP_ADDI, 2, 0);
        add_instr(OP_J, 0, 0);
        run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
